// File: rtl/async_pulse_tx.sv
// Pulse transmitter: each accepted trig becomes a HIGH_CYCLES-wide high level on
// async_sig followed by at least LOW_CYCLES low cycles, so a slower clock domain can edge-detect it.
module async_pulse_tx #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              clr_ovf,
  output logic              async_sig,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0]  HIGH_LOAD = TMR_W'(HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOW_LOAD  = TMR_W'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [PEND_W-1:0] pending_nxt;
  logic              last_low;
  logic              start;
  logic              drop;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    pending_nxt = pending;
    last_low    = (state == LOW) && (timer == '0);
    start       = ((state == IDLE) || last_low) && ((pending != '0) || trig);
    drop        = trig && !start && (pending == PEND_MAX);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HIGH;
          timer_nxt = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (timer == '0) begin
          state_nxt = LOW;
          timer_nxt = LOW_LOAD;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      LOW: begin
        if (timer != '0) begin
          timer_nxt = timer - TMR_W'(1);
        end else if (start) begin
          // Re-arm straight from the last low cycle so back-to-back pulses have no idle gap.
          state_nxt = HIGH;
          timer_nxt = HIGH_LOAD;
        end else begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    // A start with pending==0 consumes trig directly; trig plus start otherwise cancel out.
    if (start && !trig) begin
      pending_nxt = pending - PEND_W'(1);
    end else if (!start && trig && (pending != PEND_MAX)) begin
      pending_nxt = pending + PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      pending   <= '0;
      async_sig <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      pending   <= pending_nxt;
      async_sig <= (state_nxt == HIGH);
      overflow  <= drop || (overflow && !clr_ovf);
    end
  end

  assign done = last_low;
  assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_async_pulse_tx.sv
// Bench for async_pulse_tx: directed scenarios plus random traffic checked against a
// timeline model (pulse start time and a request count), with a loopback edge detector.
module tb_async_pulse_tx;

  localparam int H      = 4;
  localparam int L      = 4;
  localparam int PW     = 2;
  localparam int PMAX   = 3;
  localparam int NO_PULSE = -1000;

  logic          clk = 1'b0;
  logic          clk2 = 1'b0;
  logic          rst = 1'b0;
  logic          trig = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          async_sig;
  logic [PW-1:0] pending;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: current cycle, first-high cycle of the latest pulse, queue depth, overflow.
  int t = 0;
  int s = NO_PULSE;
  int mpend = 0;
  int movf = 0;
  int pulses = 0;

  // Loopback detector in an unrelated clock domain.
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int rises = 0;
  int falls = 0;

  async_pulse_tx #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig),
    .clr_ovf  (clr_ovf),
    .async_sig(async_sig),
    .pending  (pending),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always #3 clk2 = ~clk2;

  always @(posedge clk2) begin
    s1 <= async_sig;
    s2 <= s1;
    s3 <= s2;
    if (s2 && !s3) rises <= rises + 1;
    if (!s2 && s3) falls <= falls + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic int exp_sig();
    return (t >= s && t < s + H) ? 1 : 0;
  endfunction

  function automatic int exp_done();
    return (t == s + H + L - 1) ? 1 : 0;
  endfunction

  function automatic int exp_busy();
    return ((t >= s && t <= s + H + L - 1) || mpend != 0) ? 1 : 0;
  endfunction

  // One clock cycle: check outputs for cycle t, apply inputs, advance the model.
  task automatic step(input logic tr, input logic cl);
    int can;
    int st;
    int drp;
    @(negedge clk);
    chk("async_sig", int'(async_sig), exp_sig());
    chk("pending",   int'(pending),   mpend);
    chk("busy",      int'(busy),      exp_busy());
    chk("done",      int'(done),      exp_done());
    chk("overflow",  int'(overflow),  movf);
    trig    = tr;
    clr_ovf = cl;
    can = (t >= s + H + L - 1) ? 1 : 0;
    st  = (can != 0 && (mpend != 0 || tr)) ? 1 : 0;
    drp = 0;
    if (st != 0) begin
      if (!tr) mpend--;
      s = t + 1;
      pulses++;
    end else if (tr) begin
      if (mpend == PMAX) drp = 1;
      else mpend++;
    end
    if (drp != 0) movf = 1;
    else if (cl) movf = 0;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for clk.
  task automatic mid_reset();
    @(negedge clk);
    trig    = 1'b0;
    clr_ovf = 1'b0;
    chk("pre_rst_sig", int'(async_sig), exp_sig());
    chk("pre_rst_pending", int'(pending), mpend);
    #2 rst = 1'b1;
    #1;
    chk("rst_sig",      int'(async_sig), 0);
    chk("rst_pending",  int'(pending),   0);
    chk("rst_busy",     int'(busy),      0);
    chk("rst_done",     int'(done),      0);
    chk("rst_overflow", int'(overflow),  0);
    mpend = 0;
    movf  = 0;
    s     = NO_PULSE;
    t++;
    @(negedge clk);
    rst = 1'b0;
    t++;
  endtask

  initial begin
    int r0;
    #1 rst = 1'b1;
    #1;
    chk("init_sig",      int'(async_sig), 0);
    chk("init_pending",  int'(pending),   0);
    chk("init_busy",     int'(busy),      0);
    chk("init_overflow", int'(overflow),  0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single request from idle.
    r0 = rises;
    step(1'b1, 1'b0);
    idle(12);
    chk("single_rises", rises - r0, 1);

    // Three consecutive requests, then back-to-back pulses.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(30);

    // Five requests in a row: queue saturates and one is dropped; then clear overflow.
    r0 = rises;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    idle(40);
    chk("sat_rises", rises - r0, 4);
    chk("sat_overflow", int'(overflow), 1);
    step(1'b0, 1'b1);
    idle(2);

    // Request landing on the last low cycle with one already queued.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(6);
    step(1'b1, 1'b0);
    idle(30);

    // Overflow set and clear in the same cycle: set wins.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("set_wins_ovf", int'(overflow), 1);
    idle(40);

    // Reset mid-HIGH with two queued, then a normal pulse after release.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    mid_reset();
    r0 = rises;
    idle(2);
    step(1'b1, 1'b0);
    idle(12);
    chk("post_rst_rises", rises - r0, 1);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 1200; i++) begin
      if (i % 300 == 299) mid_reset();
      else step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end
    idle(60);
    #40;
    chk("loop_rises", rises, pulses);
    chk("loop_falls", falls, pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_pulse_tx.md
ASYNC_PULSE_TX -- requirements
Module: AsyncPulseTx

Interface
REQ-001 The block SHALL have parameter HIGH_CYCLES, default 4, number of clk cycles async_sig is held high per pulse (legal >= 2).
REQ-002 The block SHALL have parameter LOW_CYCLES, default 4, minimum clk cycles async_sig is held low after each pulse (legal >= 2).
REQ-003 The block SHALL have parameter PEND_W, default 4, width of the pending-request counter (max 2^PEND_W-1).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port trig  input  1  synchronous single-cycle pulse request, one pulse per high cycle.
REQ-007 The block SHALL have port clr_ovf  input  1  synchronous clear of overflow.
REQ-008 The block SHALL have port async_sig  output  1  registered level for a downstream clock-domain edge detector.
REQ-009 The block SHALL have port pending  output  PEND_W  queued requests not yet started.
REQ-010 The block SHALL have port busy  output  1  high when state != IDLE or pending != 0.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse on completion of each LOW phase.
REQ-012 The block SHALL have port overflow  output  1  sticky flag, a request was dropped.

Function
REQ-013 The block SHALL implement states IDLE, HIGH, LOW with a down-counter timer sized for max(HIGH_CYCLES, LOW_CYCLES).
REQ-014 async_sig SHALL be a flop output: 1 exactly in HIGH, 0 in IDLE and LOW; no combinational path from trig.
REQ-015 start SHALL be asserted when (state==IDLE, or state==LOW with timer at last cycle) and (pending!=0 or trig).
REQ-016 On start the FSM SHALL enter HIGH, timer loaded HIGH_CYCLES-1; async_sig rises the cycle after start.
REQ-017 HIGH SHALL last exactly HIGH_CYCLES cycles, then LOW SHALL last exactly LOW_CYCLES cycles.
REQ-018 At the last LOW cycle done SHALL pulse for one cycle; next state HIGH if start, else IDLE.
REQ-019 pending_next SHALL equal pending + trig_accepted - start, where start consumes trig directly when pending==0.
REQ-020 trig with pending at max and no start that cycle SHALL be dropped, pending unchanged, overflow set.
REQ-021 Simultaneous trig and start with pending>0 SHALL leave pending unchanged.
REQ-022 overflow SHALL clear on clr_ovf; simultaneous set and clr_ovf SHALL leave overflow set.
REQ-023 trig arriving during HIGH or LOW SHALL be queued, never extend or truncate the current pulse.
REQ-024 Back-to-back pulses SHALL have exactly LOW_CYCLES low cycles between them (no IDLE bubble).

Reset
REQ-025 On rst asserted the block SHALL immediately force state IDLE, async_sig 0, pending 0, timer 0, done 0, overflow 0, independent of clk.
REQ-026 Reset mid-HIGH SHALL drop async_sig to 0 without completing the pulse; queued requests are discarded.
REQ-027 After rst deassertion the first trig SHALL behave per REQ-016.

Verification (HIGH_CYCLES=4, LOW_CYCLES=4, PEND_W=2)
REQ-028 Single trig at cycle 0 in IDLE -> async_sig high cycles 1-4, low 5-8, done high at cycle 8, busy low from cycle 9, pending stays 0.
REQ-029 trig at cycles 0,1,2 -> pending 1 then 2 then 1 at cycle 8 start, three pulses with exactly 4 low cycles between, pending 0 after last start.
REQ-030 Five trigs during first HIGH phase -> pending saturates at 3, overflow set on 4th queued trig, 4 pulses total emitted; clr_ovf then clears overflow.
REQ-031 trig coincident with last LOW cycle, pending 1 -> pending stays 1, next HIGH begins immediately, no IDLE cycle.
REQ-032 rst asserted mid-HIGH with pending 2 -> async_sig 0 same cycle, pending 0, busy 0; trig after release produces a normal 4-cycle pulse.
REQ-033 Loopback: async_sig into a 3-flop synchronizer edge detector on unrelated clock -> exactly one rise and one fall detected per requested pulse.
